// File: rtl/voting_pkg.sv
// ----------------------------------------------------------------------------
// voting_pkg
//   Shared definitions for the parametrised voting machine.
//   - session_state_e : session FSM states with their external encodings
//   - STATE_W         : width of the encoded session state
//   - sat_max()       : all-ones value of a counter of the given width, used
//                       as the saturation ceiling for tallies and totals
// ----------------------------------------------------------------------------
package voting_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } session_state_e;

  // Largest value representable in 'width' bits (width 1..64).
  function automatic logic [63:0] sat_max(input int width);
    sat_max = (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/voting_machine_n_if.sv
// ----------------------------------------------------------------------------
// voting_machine_n_if
//   Bundles the session controls, vote handshake and result bus of the
//   voting machine.
//   slave  : the voting machine (consumes controls, drives results)
//   master : the controlling/reporting side
//   Signals: open_session, close_session, enable_btn, sel -> machine
//            tally_flat, total_votes, vote_ack, vote_reject, session_state,
//            winner, tie, result_valid <- machine
//   With VOTE_LOCKOUT_EN defined: voter_next -> machine, locked <- machine.
// ----------------------------------------------------------------------------
interface voting_machine_n_if #(
  parameter int NUM_CAND  = 8,
  parameter int CTR_WIDTH = 16,
  parameter int SEL_WIDTH = $clog2(NUM_CAND)
);
  logic                          open_session;
  logic                          close_session;
  logic                          enable_btn;
  logic [SEL_WIDTH-1:0]          sel;
  logic [NUM_CAND*CTR_WIDTH-1:0] tally_flat;
  logic [CTR_WIDTH+SEL_WIDTH-1:0] total_votes;
  logic                          vote_ack;
  logic                          vote_reject;
  logic [1:0]                    session_state;
  logic [SEL_WIDTH-1:0]          winner;
  logic                          tie;
  logic                          result_valid;
`ifdef VOTE_LOCKOUT_EN
  logic                          voter_next;
  logic                          locked;
`endif

  modport slave (
    input  open_session, close_session, enable_btn, sel,
`ifdef VOTE_LOCKOUT_EN
    input  voter_next,
    output locked,
`endif
    output tally_flat, total_votes, vote_ack, vote_reject,
    output session_state, winner, tie, result_valid
  );

  modport master (
    output open_session, close_session, enable_btn, sel,
`ifdef VOTE_LOCKOUT_EN
    output voter_next,
    input  locked,
`endif
    input  tally_flat, total_votes, vote_ack, vote_reject,
    input  session_state, winner, tie, result_valid
  );
endinterface

// File: rtl/voting_machine_n_btn_edge_detect.sv
// ----------------------------------------------------------------------------
// btn_edge_detect
//   Rising-edge pulse generator. pulse is high in the first cycle level is
//   seen high after being low. The history register clears on reset.
//   Ports: clk, rst (sync, active-high), level (in), pulse (out)
// ----------------------------------------------------------------------------
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic prev_r;

  // Remember last cycle's level.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  assign pulse = level & ~prev_r;
endmodule

// File: rtl/voting_machine_n.sv
// ----------------------------------------------------------------------------
// voting_machine_n
//   Parametrised N-candidate voting machine with a session FSM
//   (IDLE/OPEN/SCAN/DONE), edge-detected vote button, saturating tallies and
//   a one-candidate-per-cycle winner/tie scan after the session closes.
//   Ports: clk, rst (sync, active-high), bus (voting_machine_n_if.slave)
//   Optional feature macro: VOTE_LOCKOUT_EN (per-voter lockout with
//   voter_next/locked on the bus).
// ----------------------------------------------------------------------------
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int NUM_CAND  = 8,
  parameter int CTR_WIDTH = 16,
  parameter int SEL_WIDTH = $clog2(NUM_CAND)
) (
  input logic              clk,
  input logic              rst,
  voting_machine_n_if.slave bus
);
  localparam int TOT_WIDTH = CTR_WIDTH + SEL_WIDTH;
  localparam int SELX_W    = SEL_WIDTH + 1;
  localparam logic [CTR_WIDTH-1:0] TALLY_MAX = CTR_WIDTH'(sat_max(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] TALLY_ONE = CTR_WIDTH'(1'b1);
  localparam logic [TOT_WIDTH-1:0] TOTAL_MAX = TOT_WIDTH'(sat_max(TOT_WIDTH));
  localparam logic [TOT_WIDTH-1:0] TOTAL_ONE = TOT_WIDTH'(1'b1);
  // One bit wider than sel so NUM_CAND = 2^SEL_WIDTH is representable.
  localparam logic [SELX_W-1:0]    CAND_LIM  = SELX_W'(NUM_CAND);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_CAND - 1);
  localparam logic [SEL_WIDTH-1:0] IDX_ONE   = SEL_WIDTH'(1'b1);

  session_state_e state_r, state_n;

  logic [CTR_WIDTH-1:0] tally_r [NUM_CAND];
  logic [TOT_WIDTH-1:0] total_r;
  logic [CTR_WIDTH-1:0] tally_sel_s;
  logic [CTR_WIDTH-1:0] scan_val_s;
  logic [NUM_CAND*CTR_WIDTH-1:0] tally_flat_s;

  logic vote_evt_s;
  logic sel_ok_s;
  logic accept_s;
  logic reject_s;
  logic open_clear_s;
  logic scan_last_s;
  logic lock_block_s;

  logic [SEL_WIDTH-1:0] scan_idx_r;
  logic [CTR_WIDTH-1:0] run_max_r, run_max_n;
  logic [SEL_WIDTH-1:0] best_r, best_n;
  logic                 run_tie_r, run_tie_n;

  logic [SEL_WIDTH-1:0] winner_r;
  logic                 tie_r;
  logic                 ack_r;
  logic                 rej_r;
  logic                 valid_r;

  btn_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (bus.enable_btn),
    .pulse (vote_evt_s)
  );

  // Select the tally addressed by sel (zero when sel is out of range).
  always_comb begin
    tally_sel_s = {CTR_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CAND; i++) begin
      tally_sel_s = tally_sel_s | (tally_r[i] & {CTR_WIDTH{SEL_WIDTH'(i) == bus.sel}});
    end
  end

  // Select the tally under the scan pointer.
  always_comb begin
    scan_val_s = {CTR_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CAND; i++) begin
      scan_val_s = scan_val_s | (tally_r[i] & {CTR_WIDTH{SEL_WIDTH'(i) == scan_idx_r}});
    end
  end

`ifdef VOTE_LOCKOUT_EN
  logic locked_r;
  assign lock_block_s = locked_r;
`else
  assign lock_block_s = 1'b0;
`endif

  assign sel_ok_s     = ({1'b0, bus.sel} < CAND_LIM);
  assign accept_s     = vote_evt_s && (state_r == S_OPEN) && sel_ok_s &&
                        (tally_sel_s != TALLY_MAX) && !lock_block_s;
  assign reject_s     = vote_evt_s && !accept_s;
  assign open_clear_s = (state_r == S_DONE) && bus.open_session;
  assign scan_last_s  = (scan_idx_r == LAST_IDX);

  // Session next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.open_session) state_n = S_OPEN;
        else                  state_n = S_IDLE;
      end
      S_OPEN: begin
        if (bus.close_session) state_n = S_SCAN;
        else                   state_n = S_OPEN;
      end
      S_SCAN: begin
        if (scan_last_s) state_n = S_DONE;
        else             state_n = S_SCAN;
      end
      S_DONE: begin
        if (bus.open_session) state_n = S_OPEN;
        else                  state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One scan step: index 0 seeds the running max, later candidates only
  // replace it when strictly greater, so the lowest index wins a tie.
  always_comb begin
    run_max_n = run_max_r;
    best_n    = best_r;
    run_tie_n = run_tie_r;
    if (scan_idx_r == {SEL_WIDTH{1'b0}}) begin
      run_max_n = scan_val_s;
      best_n    = {SEL_WIDTH{1'b0}};
      run_tie_n = 1'b0;
    end else if (scan_val_s > run_max_r) begin
      run_max_n = scan_val_s;
      best_n    = scan_idx_r;
      run_tie_n = 1'b0;
    end else if (scan_val_s == run_max_r) begin
      run_tie_n = 1'b1;
    end else begin
      run_max_n = run_max_r;
    end
  end

  // Session state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Tallies and total: cleared on reset or reopen, bumped on accepted votes.
  always_ff @(posedge clk) begin
    if (rst || open_clear_s) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        tally_r[i] <= {CTR_WIDTH{1'b0}};
      end
      total_r <= {TOT_WIDTH{1'b0}};
    end else if (accept_s) begin
      // accept_s already guarantees the selected tally is below saturation.
      for (int i = 0; i < NUM_CAND; i++) begin
        if (SEL_WIDTH'(i) == bus.sel) begin
          tally_r[i] <= tally_r[i] + TALLY_ONE;
        end
      end
      if (total_r != TOTAL_MAX) begin
        total_r <= total_r + TOTAL_ONE;
      end
    end
  end

  // Scan pointer and running max/best/tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_r <= {SEL_WIDTH{1'b0}};
      run_max_r  <= {CTR_WIDTH{1'b0}};
      best_r     <= {SEL_WIDTH{1'b0}};
      run_tie_r  <= 1'b0;
    end else if (state_r == S_SCAN) begin
      scan_idx_r <= scan_last_s ? {SEL_WIDTH{1'b0}} : scan_idx_r + IDX_ONE;
      run_max_r  <= run_max_n;
      best_r     <= best_n;
      run_tie_r  <= run_tie_n;
    end else begin
      scan_idx_r <= {SEL_WIDTH{1'b0}};
    end
  end

  // Published result, captured on the final scan step.
  always_ff @(posedge clk) begin
    if (rst || open_clear_s) begin
      winner_r <= {SEL_WIDTH{1'b0}};
      tie_r    <= 1'b0;
    end else if ((state_r == S_SCAN) && scan_last_s) begin
      winner_r <= best_n;
      tie_r    <= run_tie_n;
    end
  end

  // Registered handshake pulses and result_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rej_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      ack_r   <= accept_s;
      rej_r   <= reject_s;
      valid_r <= (state_n == S_DONE);
    end
  end

`ifdef VOTE_LOCKOUT_EN
  // Lockout: set by an accepted vote, cleared by voter_next or a new session.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_r <= 1'b0;
    end else if (accept_s) begin
      locked_r <= 1'b1;
    end else if (bus.voter_next || ((state_n == S_OPEN) && (state_r != S_OPEN))) begin
      locked_r <= 1'b0;
    end
  end
  assign bus.locked = locked_r;
`endif

  // Pack tallies onto the flat output bus.
  always_comb begin
    tally_flat_s = {(NUM_CAND*CTR_WIDTH){1'b0}};
    for (int i = 0; i < NUM_CAND; i++) begin
      tally_flat_s[i*CTR_WIDTH +: CTR_WIDTH] = tally_r[i];
    end
  end

  assign bus.tally_flat    = tally_flat_s;
  assign bus.total_votes   = total_r;
  assign bus.vote_ack      = ack_r;
  assign bus.vote_reject   = rej_r;
  assign bus.session_state = state_r;
  assign bus.winner        = winner_r;
  assign bus.tie           = tie_r;
  assign bus.result_valid  = valid_r;
endmodule
